regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters:
  - the pipeline writeback stage, which has priority;
  - the multi-cycle unit (mul/div) result path, which uses a valid/ready handshake.
- Multi-cycle results wait in a small queue.
- A starvation counter forces a one-cycle pipeline stall so that queued results drain.
- Outputs drive the register file's we/wn/d directly; pend_a/pend_b feed decode hazard detection.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/wq_fifo.sv | 88 ++++++++
 rtl/regfile_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write arbiter.
// Holds the fairness FSM encoding and the queued write-request layout.
package regfile_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  wn;
        logic [DATA_W-1:0] d;
    } wreq_t;

endpackage

// File: rtl/wq_fifo.sv
// Small compacting queue of pending multi-cycle register writes.
// Entries matching a killed address are squeezed out; order is kept.
module wq_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push_i,
    input  logic [REG_W-1:0]  push_wn_i,
    input  logic [DATA_W-1:0] push_d_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [REG_W-1:0]  kill_wn_i,
    input  logic [REG_W-1:0]  look_a_i,
    input  logic [REG_W-1:0]  look_b_i,
    output logic [REG_W-1:0]  head_wn_o,
    output logic [DATA_W-1:0] head_d_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              nonempty_next_o,
    output logic [DEPTH-1:0]  match_a_o,
    output logic [DEPTH-1:0]  match_b_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    wreq_t            ent_q [DEPTH];
    wreq_t            ent_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CW-1:0]    n;
    logic             keep;
    logic             push_ok;

    // Survivors are packed toward slot 0, so the head is always slot 0.
    always_comb begin
        ent_d   = ent_q;
        v_d     = '0;
        n       = '0;
        keep    = 1'b0;
        push_ok = push_i && !(kill_i && push_wn_i == kill_wn_i);
        for (int i = 0; i < DEPTH; i++) begin
            keep = v_q[i]
                && !(pop_i && i == 0)
                && !(kill_i && ent_q[i].wn == kill_wn_i);
            if (keep) begin
                ent_d[n[CW-2:0]] = ent_q[i];
                v_d[n[CW-2:0]]   = 1'b1;
                n = n + CW'(1);
            end
        end
        if (push_ok && !n[CW-1]) begin
            ent_d[n[CW-2:0]].wn = push_wn_i;
            ent_d[n[CW-2:0]].d  = push_d_i;
            v_d[n[CW-2:0]]      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            ent_q <= ent_d;
        end
    end

    always_comb begin
        match_a_o = '0;
        match_b_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_a_o[i] = v_q[i] && ent_q[i].wn == look_a_i;
            match_b_o[i] = v_q[i] && ent_q[i].wn == look_b_i;
        end
    end

    assign head_wn_o       = ent_q[0].wn;
    assign head_d_o        = ent_q[0].d;
    assign empty_o         = !v_q[0];
    assign full_o          = v_q[DEPTH-1];
    assign nonempty_next_o = v_d[0];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register file write port between writeback and mul/div.
// A starvation counter forces a one-cycle stall to drain queued results.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wb_we,
    input  logic [REG_W-1:0]    wb_wn,
    input  logic [DATA_W-1:0]   wb_d,
    input  logic                md_valid,
    input  logic [REG_W-1:0]    md_wn,
    input  logic [DATA_W-1:0]   md_d,
    output logic                md_ready,
    output logic                we,
    output logic [REG_W-1:0]    wn,
    output logic [DATA_W-1:0]   d,
    output logic                stall,
    input  logic [REG_W-1:0]    rna,
    input  logic [REG_W-1:0]    rnb,
    output logic                pend_a,
    output logic                pend_b
);

    localparam logic [3:0] CMAX = 4'(STARVE_MAX);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [REG_W-1:0]  head_wn;
    logic [DATA_W-1:0] head_d;
    logic              empty;
    logic              full;
    logic              ne_next;
    logic              push;
    logic              pop;
    logic              wb_grant;
    logic [DEPTH-1:0]  match_a;
    logic [DEPTH-1:0]  match_b;

    assign md_ready = !full && !clr;
    assign push     = md_valid && md_ready && (md_wn != '0);
    assign stall    = (state_q == FORCE) && !clr;

    wq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk            (clk),
        .clr            (clr),
        .push_i         (push),
        .push_wn_i      (md_wn),
        .push_d_i       (md_d),
        .pop_i          (pop),
        .kill_i         (wb_grant),
        .kill_wn_i      (wb_wn),
        .look_a_i       (rna),
        .look_b_i       (rnb),
        .head_wn_o      (head_wn),
        .head_d_o       (head_d),
        .empty_o        (empty),
        .full_o         (full),
        .nonempty_next_o(ne_next),
        .match_a_o      (match_a),
        .match_b_o      (match_b)
    );

    always_comb begin
        pop      = 1'b0;
        wb_grant = 1'b0;
        we       = 1'b0;
        wn       = '0;
        d        = '0;
        if (!clr) begin
            if (stall && !empty) begin
                pop = 1'b1;
            end else if (wb_we && wb_wn != '0) begin
                wb_grant = 1'b1;
            end else if (!empty) begin
                pop = 1'b1;
            end
        end
        if (pop) begin
            we = 1'b1;
            wn = head_wn;
            d  = head_d;
        end else if (wb_grant) begin
            we = 1'b1;
            wn = wb_wn;
            d  = wb_d;
        end
    end

    // Reaching the limit wins even if kills just emptied the queue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FORCE: begin
                cnt_d   = '0;
                state_d = ne_next ? WAIT : IDLE;
            end
            default: begin
                if (pop) begin
                    cnt_d = '0;
                end else if (!empty) begin
                    cnt_d = cnt_q + 4'd1;
                end
                if (cnt_d == CMAX) begin
                    state_d = FORCE;
                end else if (ne_next) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pend_a = !clr && (rna != '0)
        && ((|match_a) || (md_valid && md_wn == rna));
    assign pend_b = !clr && (rnb != '0)
        && ((|match_b) || (md_valid && md_wn == rnb));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised bench for regfile_wr_arbiter against a queue-based model.
// Directed scenarios pin the model with hand-computed literal values.
module tb_regfile_wr_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        wb_we;
    logic [4:0]  wb_wn;
    logic [31:0] wb_d;
    logic        md_valid;
    logic [4:0]  md_wn;
    logic [31:0] md_d;
    logic        md_ready;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        stall;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        pend_a;
    logic        pend_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .wb_we   (wb_we),
        .wb_wn   (wb_wn),
        .wb_d    (wb_d),
        .md_valid(md_valid),
        .md_wn   (md_wn),
        .md_d    (md_d),
        .md_ready(md_ready),
        .we      (we),
        .wn      (wn),
        .d       (d),
        .stall   (stall),
        .rna     (rna),
        .rnb     (rnb),
        .pend_a  (pend_a),
        .pend_b  (pend_b)
    );

    typedef struct {
        logic [4:0]  wn;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   m_cnt   = 0;
    bit   m_force = 1'b0;

    bit          e_ready;
    bit          e_we;
    bit          e_stall;
    bit          e_pa;
    bit          e_pb;
    bit          e_pop;
    bit          e_wbg;
    logic [4:0]  e_wn;
    logic [31:0] e_d;

    function automatic bit queued(logic [4:0] r);
        foreach (mq[i]) begin
            if (mq[i].wn == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_eval();
        e_ready = !clr && (mq.size() < DEPTH);
        e_stall = !clr && m_force;
        e_pop   = 1'b0;
        e_wbg   = 1'b0;
        if (!clr) begin
            if (e_stall && mq.size() > 0) e_pop = 1'b1;
            else if (wb_we && wb_wn != 0) e_wbg = 1'b1;
            else if (mq.size() > 0) e_pop = 1'b1;
        end
        e_we = e_pop || e_wbg;
        e_wn = e_pop ? mq[0].wn : (e_wbg ? wb_wn : 5'd0);
        e_d  = e_pop ? mq[0].d : (e_wbg ? wb_d : 32'd0);
        e_pa = !clr && rna != 0 && (queued(rna) || (md_valid && md_wn == rna));
        e_pb = !clr && rnb != 0 && (queued(rnb) || (md_valid && md_wn == rnb));
    endtask

    task automatic model_update();
        bit   had;
        ent_t k[$];
        if (clr) begin
            mq.delete();
            m_cnt   = 0;
            m_force = 1'b0;
            return;
        end
        had = mq.size() > 0;
        if (e_pop) void'(mq.pop_front());
        if (e_wbg) begin
            foreach (mq[i]) begin
                if (mq[i].wn != wb_wn) k.push_back(mq[i]);
            end
            mq = k;
        end
        if (md_valid && e_ready && md_wn != 0 && !(e_wbg && md_wn == wb_wn))
            mq.push_back('{md_wn, md_d});
        if (m_force) begin
            m_force = 1'b0;
            m_cnt   = 0;
        end else begin
            if (e_pop) m_cnt = 0;
            else if (had) m_cnt++;
            if (m_cnt == STARVE_MAX) m_force = 1'b1;
            else if (mq.size() == 0) m_cnt = 0;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_eval();
        chk("md_ready", md_ready, e_ready);
        chk("we", we, e_we);
        chk("wn", wn, e_wn);
        chk("d", d, e_d);
        chk("stall", stall, e_stall);
        chk("pend_a", pend_a, e_pa);
        chk("pend_b", pend_b, e_pb);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(bit c, bit w, logic [4:0] ww, logic [31:0] wd,
                         bit v, logic [4:0] mw, logic [31:0] mdd);
        clr      = c;
        wb_we    = w;
        wb_wn    = ww;
        wb_d     = wd;
        md_valid = v;
        md_wn    = mw;
        md_d     = mdd;
        #1;
    endtask

    initial begin
        bit hold = 1'b0;
        int dens;
        rna = 5'd0;
        rnb = 5'd0;

        // reset with a request pending
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1, 9, 32'h99);
            chk("rst_we", we, 0);
            chk("rst_ready", md_ready, 0);
            chk("rst_stall", stall, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_ready", md_ready, 1);
        chk("post_rst_we", we, 0);
        tick();

        // idle path: one-cycle latency
        drive(0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF);
        chk("idle_accept_we", we, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("idle_we", we, 1);
        chk("idle_wn", wn, 5);
        chk("idle_d", d, 32'hDEAD_BEEF);
        tick();
        chk("idle_drained", we, 0);
        tick();

        // md_wn == 0 is swallowed
        drive(0, 0, 0, 0, 1, 0, 32'h55);
        chk("r0_ready", md_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_no_we", we, 0);
        tick();

        // priority, full queue, starvation drain
        rna = 5'd3;
        rnb = 5'd6;
        drive(0, 1, 10, 32'hA0, 1, 3, 32'h33);
        chk("pri_ready", md_ready, 1);
        chk("pri_wn0", wn, 10);
        tick();
        drive(0, 1, 10, 32'hA1, 1, 4, 32'h44);
        chk("pri_pend_a", pend_a, 1);
        chk("pri_wn1", wn, 10);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 10, 32'hB0 + i, 0, 0, 0);
            chk("full_ready", md_ready, 0);
            chk("starve_stall", stall, 0);
            chk("starve_wn", wn, 10);
            tick();
        end
        drive(0, 1, 10, 32'hC0, 0, 0, 0);
        chk("force1_stall", stall, 1);
        chk("force1_we", we, 1);
        chk("force1_wn", wn, 3);
        chk("force1_d", d, 32'h33);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 10, 32'hD0 + i, 0, 0, 0);
            chk("win2_stall", stall, 0);
            chk("win2_wn", wn, 10);
            tick();
        end
        drive(0, 1, 10, 32'hE0, 0, 0, 0);
        chk("force2_stall", stall, 1);
        chk("force2_wn", wn, 4);
        chk("force2_d", d, 32'h44);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("after_force_stall", stall, 0);
        chk("after_force_we", we, 0);
        tick();

        // WAW kill of a queued entry
        rna = 5'd7;
        rnb = 5'd7;
        drive(0, 1, 12, 32'h12, 1, 7, 32'h11);
        chk("waw_incoming_pend", pend_b, 1);
        tick();
        drive(0, 1, 7, 32'h22, 0, 0, 0);
        chk("waw_queued_pend", pend_a, 1);
        chk("waw_wn", wn, 7);
        chk("waw_d", d, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("waw_pend_drop", pend_a, 0);
        chk("waw_no_md", we, 0);
        tick();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            dens  = (c < 1500) ? 9 : 4;
            clr   = ($urandom_range(0, 63) == 0);
            wb_we = ($urandom_range(0, 9) < dens);
            wb_wn = 5'($urandom_range(0, 7));
            wb_d  = $urandom;
            if (!hold) begin
                md_valid = 1'($urandom_range(0, 1));
                md_wn    = 5'($urandom_range(0, 7));
                md_d     = $urandom;
            end
            rna = 5'($urandom_range(0, 7));
            rnb = 5'($urandom_range(0, 7));
            #1;
            tick();
            hold = md_valid && !e_ready && !clr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
